mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

MEM-stage main-memory access controller: the responder side of the `main_mem_read` / `main_mem_write` request that the EX/MEM pipeline register presents. It turns a one-cycle pipeline request into a req/ack transaction on a wait-stated memory bus. Until the transaction completes it stalls the pipeline by driving the EX/MEM enable low. It returns read data to the MEM/WB path and flags bus timeouts.

## Interface
Parameters:
- `ADDR_W`, 16, memory address width.
- `DATA_W`, 16, data width.
- `TIMEOUT`, 255, maximum cycles waiting for `mem_ack`; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `main_mem_read`  in  1  read request from EX/MEM.
- `main_mem_write`  in  1  write request from EX/MEM.
- `addr_mem`  in  ADDR_W  address; ALU result from EX/MEM.
- `wdata_mem`  in  DATA_W  store data from EX/MEM.
- `mem_req`  out  1  bus request, registered.
- `mem_we`  out  1  1 = write, registered.
- `mem_addr`  out  ADDR_W  latched address, registered.
- `mem_wdata`  out  DATA_W  latched store data, registered.
- `mem_ack`  in  1  one-cycle completion pulse from memory.
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`.
- `stall`  out  1  to pipeline; `en_exmem = ~stall` and earlier stages hold.
- `rdata`  out  DATA_W  captured read data.
- `rdata_valid`  out  1  one-cycle pulse when `rdata` is updated.
- `bus_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - If `main_mem_write` or `main_mem_read` is 1, latch addr/wdata/we into the bus registers, set `mem_req`=1, clear the wait counter, and go to BUSY.
  - If both requests are 1, write wins.
- BUSY:
  - `mem_req` held at 1; addr, data and we are stable.
  - The wait counter increments each cycle without ack.
  - On `mem_ack`: `mem_req`→0 and go to DONE. For a read, also `rdata`←`mem_rdata` and `rdata_valid`=1 in DONE.
  - If the counter reaches `TIMEOUT` (when nonzero) without ack: `mem_req`→0, `bus_err`←1 (sticky), and go to DONE. A read then gets `rdata`=all-ones and `rdata_valid`=1.
- DONE: lasts exactly one cycle, then IDLE. The pipeline advances at the end of DONE, so the same request is never re-issued.
- `stall` (combinational) = (IDLE and (read or write)) or BUSY. It is 0 in DONE and in IDLE with no request.
- `rdata` holds its value until the next read completes. Writes never modify `rdata`.
- `mem_ack` outside BUSY is ignored.
- A flush arriving while BUSY does not abort the bus transaction; it completes normally.
- Reset (any time, including mid-transaction):
  - State→IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `rdata`, `rdata_valid`, `bus_err` all → 0.
  - `stall` follows the IDLE equation.

## Timing
- Request seen in cycle 0, with `stall`=1 combinationally.
- Edge 1: BUSY, `mem_req`=1.
- Ack after W wait cycles (W=0 means ack in the first BUSY cycle), then DONE.
- Total stall = W+2 cycles. Read data is valid in the DONE cycle, 1 cycle after `mem_ack`.
- Back-to-back memory instructions: the next request is seen in the IDLE cycle right after DONE. Minimum spacing is 3 cycles per access.
- Timeout: DONE is entered after exactly `TIMEOUT` BUSY cycles. The counter is ceil(log2(TIMEOUT+1)) bits and saturates; it never wraps.
- The bus outputs are registered. There is no combinational path from `mem_ack` to `mem_req`.

## Structure
- Package `mem_access_pkg`:
  - state enum typedef `mem_state_t` {IDLE, BUSY, DONE};
  - `MEM_ERR_DATA` constant (all-ones);
  - default `TIMEOUT`.
- Sub-module `wait_counter`: clear, enable, saturating count, and terminal-count compare against `TIMEOUT`.
- All other registers use the team flop primitive with async active-low reset.

## Test plan
- Read, W=0, `mem_rdata`=16'h1234:
  - `stall` high for 2 cycles;
  - `mem_req` high 1 cycle with `mem_we`=0 and `mem_addr`=`addr_mem`;
  - `rdata`=16'h1234 with `rdata_valid` pulsed in DONE.
- Write, W=3, addr 16'h0040, data 16'hBEEF:
  - `mem_req`/`mem_we` high 4 cycles;
  - `mem_wdata`=16'hBEEF;
  - `stall` 5 cycles;
  - `rdata` unchanged.
- Read and write both asserted: the write is performed, with `mem_we`=1 and `rdata_valid` never pulsed.
- No ack, `TIMEOUT`=8:
  - `mem_req` drops after 8 BUSY cycles;
  - `bus_err`=1 and stays 1;
  - `rdata`=16'hFFFF.
- Reset pulled low in the 2nd BUSY cycle:
  - `mem_req`, `bus_err`, `rdata` → 0 immediately;
  - a late `mem_ack` is ignored;
  - the next request starts cleanly.
- Two back-to-back loads, W=1: the second `mem_req` rises exactly 4 cycles after the first.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage main-memory access controller.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Widest data bus the error pattern covers; users slice it to DATA_W.
    localparam int MAX_DATA_W = 64;

    // Read data returned when a transaction times out.
    localparam logic [MAX_DATA_W-1:0] MEM_ERR_DATA = '1;

    // Wait cycles allowed for mem_ack before declaring a bus error.
    localparam int DEFAULT_TIMEOUT = 255;

    // Counter width able to hold the value TIMEOUT; a disabled timeout still
    // needs a one-bit counter so the port list stays legal.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Saturating wait-cycle counter with a terminal-count flag that marks the last
// BUSY cycle allowed before a bus timeout.
import mem_access_pkg::*;

module wait_counter #(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    // The counter never needs to go beyond TIMEOUT, so it stops there.
    localparam logic [CNT_W-1:0] SAT_VAL = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '1;

    // Holding TIMEOUT-1 while still waiting means this cycle is the
    // TIMEOUT-th one without an ack.
    localparam logic [CNT_W-1:0] TC_VAL = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] count;

    // Count unacknowledged BUSY cycles; clear restarts each transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != SAT_VAL)) begin
            count <= count + CNT_W'(1);
        end
    end

    // Terminal count is only meaningful while waiting and with a nonzero limit.
    always_comb begin
        expired = enable && (TIMEOUT != 0) && (count == TC_VAL);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage main-memory access controller. Converts a single pipeline
// read/write request into a req/ack bus transaction, stalls the pipeline until
// the transaction completes, returns read data and flags bus timeouts.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; a pending request is latched onto the bus
// BUSY  | mem_req held, waiting for mem_ack or the timeout
// DONE  | one-cycle completion; pipeline advances, read data valid
import mem_access_pkg::*;

module mem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              main_mem_read,
    input  logic              main_mem_write,
    input  logic [ADDR_W-1:0] addr_mem,
    input  logic [DATA_W-1:0] wdata_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              bus_err
);

    localparam logic [DATA_W-1:0] ERR_DATA = MEM_ERR_DATA[DATA_W-1:0];

    mem_state_t state;
    logic       any_req;
    logic       wait_clear;
    logic       wait_en;
    logic       timed_out;

    assign any_req    = main_mem_read || main_mem_write;
    assign wait_clear = (state == IDLE);
    assign wait_en    = (state == BUSY) && !mem_ack;

    wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (wait_clear),
        .enable  (wait_en),
        .expired (timed_out)
    );

    // Transaction FSM with registered bus outputs and read-return registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        // A simultaneous read and write resolves to the write.
                        mem_we    <= main_mem_write;
                        mem_addr  <= addr_mem;
                        mem_wdata <= wdata_mem;
                        mem_req   <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still counts as success.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (!mem_we) begin
                            rdata       <= mem_rdata;
                            rdata_valid <= 1'b1;
                        end
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                        if (!mem_we) begin
                            rdata       <= ERR_DATA;
                            rdata_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // The pipeline moves on this cycle, so the old request is
                    // not seen again.
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Stall from the moment a request appears until the bus transaction ends.
    always_comb begin
        stall = ((state == IDLE) && any_req) || (state == BUSY);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. A transaction-level model predicts
// stall length, request length, bus fields, returned data and the error flag.
module tb_mem_access_ctrl;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TMO     = 8;
    localparam int NO_ACK  = 1000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              main_mem_read = 1'b0;
    logic              main_mem_write = 1'b0;
    logic [ADDR_W-1:0] addr_mem = '0;
    logic [DATA_W-1:0] wdata_mem = '0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              stall;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              bus_err;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc_cnt = 0;

    // Model state: last returned read data and sticky error flag.
    logic [DATA_W-1:0] exp_rdata = '0;
    logic              exp_err = 1'b0;

    mem_access_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .main_mem_read  (main_mem_read),
        .main_mem_write (main_mem_write),
        .addr_mem       (addr_mem),
        .wdata_mem      (wdata_mem),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .stall          (stall),
        .rdata          (rdata),
        .rdata_valid    (rdata_valid),
        .bus_err        (bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One pipeline memory instruction; memory acks in BUSY cycle w+1.
    // Called just after a rising edge; returns just after the edge ending DONE.
    task automatic run_access(input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input int w, input logic [DATA_W-1:0] rdv,
                              output int req_cyc);
        int  stall_n;
        int  req_n;
        bit  done;
        bit  is_wr;
        bit  is_rd;
        bit  tmo_hit;
        int  exp_req_n;
        is_wr     = wr;
        is_rd     = rd && !wr;
        tmo_hit   = (w >= TMO);
        exp_req_n = tmo_hit ? TMO : w + 1;
        stall_n   = 0;
        req_n     = 0;
        done      = 0;
        req_cyc   = -1;
        main_mem_read  = rd;
        main_mem_write = wr;
        addr_mem       = a;
        wdata_mem      = d;
        mem_ack        = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (mem_req) begin
                req_n++;
                if (req_n == 1) req_cyc = cyc_cnt;
                check_val("bus_we", mem_we, is_wr);
                check_val("bus_addr", mem_addr, a);
                if (is_wr) check_val("bus_wdata", mem_wdata, d);
                mem_ack   = (req_n == w + 1);
                mem_rdata = mem_ack ? rdv : DATA_W'($urandom);
            end
            if (stall) begin
                stall_n++;
                @(posedge clk);
                #1;
                mem_ack = 1'b0;
            end else begin
                done = 1;
            end
        end
        if (!done) begin
            check_val("done_reached", 0, 1);
        end else begin
            if (is_rd) exp_rdata = tmo_hit ? {DATA_W{1'b1}} : rdv;
            if (tmo_hit) exp_err = 1'b1;
            check_val("stall_cycles", stall_n, exp_req_n + 1);
            check_val("req_cycles", req_n, exp_req_n);
            check_val("rdata_valid", rdata_valid, is_rd);
            check_val("rdata", rdata, exp_rdata);
            check_val("bus_err", bus_err, exp_err);
            check_val("done_req_low", mem_req, 0);
        end
        @(posedge clk);
        #1;
        main_mem_read  = 1'b0;
        main_mem_write = 1'b0;
    endtask

    // Idle cycles with stray acks that the controller must ignore.
    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            mem_ack   = ($urandom_range(0, 1) == 1);
            mem_rdata = DATA_W'($urandom);
            @(negedge clk);
            check_val("idle_stall", stall, 0);
            check_val("idle_req", mem_req, 0);
            check_val("idle_valid", rdata_valid, 0);
            check_val("idle_rdata", rdata, exp_rdata);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        int r0;
        int r1;
        bit rd;
        bit wr;

        // Reset values.
        #12;
        check_val("rst_req", mem_req, 0);
        check_val("rst_we", mem_we, 0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_wdata", mem_wdata, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_valid", rdata_valid, 0);
        check_val("rst_err", bus_err, 0);
        check_val("rst_stall", stall, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Read with immediate ack.
        run_access(1, 0, 16'h0102, 16'h0000, 0, 16'h1234, r0);
        // Write with three wait cycles; rdata must not move.
        run_access(0, 1, 16'h0040, 16'hBEEF, 3, 16'h5555, r0);
        // Both asserted: the write wins.
        run_access(1, 1, 16'h0077, 16'hCAFE, 1, 16'h7777, r0);
        idle_cycles(3);
        // No ack: timeout after TMO BUSY cycles.
        run_access(1, 0, 16'h0200, 16'h0000, NO_ACK, 16'h0000, r0);
        // Ack in the last permitted cycle still succeeds.
        run_access(1, 0, 16'h0204, 16'h0000, TMO - 1, 16'h4321, r0);
        // Back-to-back loads with one wait state.
        run_access(1, 0, 16'h0300, 16'h0000, 1, 16'hA001, r0);
        run_access(1, 0, 16'h0302, 16'h0000, 1, 16'hA002, r1);
        check_val("b2b_spacing", r1 - r0, 4);

        // Reset in the second BUSY cycle of a read.
        main_mem_read = 1'b1;
        addr_mem      = 16'h0500;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_val("pre_rst_req", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        exp_rdata = '0;
        exp_err   = 1'b0;
        check_val("mid_rst_req", mem_req, 0);
        check_val("mid_rst_err", bus_err, 0);
        check_val("mid_rst_rdata", rdata, 0);
        check_val("mid_rst_addr", mem_addr, 0);
        check_val("mid_rst_stall", stall, 1);
        main_mem_read = 1'b0;
        #1;
        check_val("mid_rst_stall_idle", stall, 0);
        @(negedge clk);
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check_val("late_ack_req", mem_req, 0);
        check_val("late_ack_valid", rdata_valid, 0);
        check_val("late_ack_rdata", rdata, 0);
        check_val("late_ack_stall", stall, 0);
        @(posedge clk);
        #1;
        run_access(1, 0, 16'h0600, 16'h0000, 2, 16'h9876, r0);

        // Randomised transactions against the model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       begin rd = 1; wr = 1; end
                1:       begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 0; end
            endcase
            run_access(rd, wr, ADDR_W'($urandom), DATA_W'($urandom),
                       $urandom_range(0, TMO + 3), DATA_W'($urandom), r0);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
